// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// Count width covers 0..DEPTH inclusive.
package fifo_pkg;

  typedef enum logic {
    RD_STD,
    RD_FWFT
  } rd_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage.
// Synchronous write, registered read with read enable.
module fifo_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is cleared; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost levels,
// sticky errors and optional first-word-fall-through read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  parameter  int FWFT   = 0,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  input  logic [CNT_W-1:0]  af_level,
  input  logic [CNT_W-1:0]  ae_level,
  input  logic              clr_err,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int       AW   = CNT_W - 1;
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_ok;
  logic              wr_ok;
  logic              ovf_ev;
  logic              unf_ev;

  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_q;

  logic              ld_byp;
  logic              ld_ram;
  logic              byp_sel;
  logic [DATA_W-1:0] byp_q;

  assign fifo_count        = count;
  assign fifo_full         = (count == CNT_W'(DEPTH));
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= af_level);
  assign fifo_almost_empty = (count <= ae_level);

  assign rd_ok  = rd_en & ~fifo_empty;
  assign wr_ok  = wr_en & (~fifo_full | rd_ok);
  assign ovf_ev = wr_en & fifo_full & ~rd_ok;
  assign unf_ev = rd_en & fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        (wr_ok & ~rd_ok): count <= count + CNT_W'(1);
        (rd_ok & ~wr_ok): count <= count - CNT_W'(1);
        default:          count <= count;
      endcase
    end
  end

  // A same-cycle event beats clr_err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev | (overflow & ~clr_err);
      underflow <= unf_ev | (underflow & ~clr_err);
    end
  end

  // FWFT head comes either from the RAM (next stored word)
  // or straight from data_in when the FIFO is (about to be) empty.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    ld_byp    = 1'b0;
    ld_ram    = 1'b0;
    if (MODE == RD_STD) begin
      ram_re = rd_ok;
    end else begin
      unique case (1'b1)
        (fifo_empty & wr_ok),
        (rd_ok & wr_ok & (count == CNT_W'(1))): begin
          ld_byp = 1'b1;
        end
        (rd_ok & (count > CNT_W'(1))): begin
          ld_ram    = 1'b1;
          ram_re    = 1'b1;
          ram_raddr = rd_ptr + AW'(1);
        end
        default: begin
          ld_byp = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byp_q   <= '0;
      byp_sel <= 1'b0;
    end else if (ld_byp) begin
      byp_q   <= data_in;
      byp_sel <= 1'b1;
    end else if (ld_ram) begin
      byp_sel <= 1'b0;
    end
  end

  assign data_out = byp_sel ? byp_q : ram_q;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard and FWFT instances
// share stimulus and are checked against a queue model.
module tb_sync_fifo_prog;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          clr_err;
  logic [DW-1:0] data_in;
  logic [CW-1:0] af_level;
  logic [CW-1:0] ae_level;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;
  logic [10:0]   s_flags, f_flags;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] m_std;
  logic [DW-1:0] m_fw;

  always #5 clk = ~clk;

  assign s_flags = {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf};
  assign f_flags = {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf};

  sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .data_in           (data_in),
    .rd_en             (rd_en),
    .data_out          (s_dout),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .clr_err           (clr_err),
    .fifo_full         (s_full),
    .fifo_empty        (s_empty),
    .fifo_almost_full  (s_af),
    .fifo_almost_empty (s_ae),
    .fifo_count        (s_count),
    .overflow          (s_ovf),
    .underflow         (s_unf)
  );

  sync_fifo_prog #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut_f (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .data_in           (data_in),
    .rd_en             (rd_en),
    .data_out          (f_dout),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .clr_err           (clr_err),
    .fifo_full         (f_full),
    .fifo_empty        (f_empty),
    .fifo_almost_full  (f_af),
    .fifo_almost_empty (f_ae),
    .fifo_count        (f_count),
    .overflow          (f_ovf),
    .underflow         (f_unf)
  );

  function automatic logic [10:0] exp_flags();
    int n;
    n = mq.size();
    return {CW'(n), n == DEPTH, n == 0,
            n >= int'(af_level), n <= int'(ae_level),
            m_ovf, m_unf};
  endfunction

  task automatic cyc(input bit w, input bit r, input bit c,
                     input logic [DW-1:0] d);
    bit rok, wok, oev, uev;
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    data_in = d;
    @(posedge clk);
    rok   = r && (mq.size() != 0);
    wok   = w && ((mq.size() < DEPTH) || rok);
    oev   = w && (mq.size() == DEPTH) && !rok;
    uev   = r && (mq.size() == 0);
    m_ovf = oev ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = uev ? 1'b1 : (c ? 1'b0 : m_unf);
    if (rok) m_std = mq.pop_front();
    if (wok) mq.push_back(d);
    if (mq.size() != 0) m_fw = mq[0];
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_std = '0;
    m_fw  = '0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (s_flags !== 11'b00000_0_1_0_1_0_0 ||
        f_flags !== 11'b00000_0_1_0_1_0_0) begin
      bad++;
      $display("FAIL reset_flags: got %b / %b want %b",
               s_flags, f_flags, 11'b00000_0_1_0_1_0_0);
    end
    total++;
    if (s_dout !== '0 || f_dout !== '0) begin
      bad++;
      $display("FAIL reset_dout: got %h / %h want 0", s_dout, f_dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, 0, 0, DW'(i));
      total++;
      if (s_flags !== exp_flags() || f_flags !== exp_flags()) begin
        bad++;
        $display("FAIL fill_flags[%0d]: got %b / %b want %b",
                 i, s_flags, f_flags, exp_flags());
      end
      if (i == 14) begin
        total++;
        if (s_af !== 1'b1 || s_full !== 1'b0) begin
          bad++;
          $display("FAIL fill_af14: got af=%b full=%b want 1 0",
                   s_af, s_full);
        end
      end
    end
    total++;
    if (s_full !== 1'b1 || s_count !== 5'd16) begin
      bad++;
      $display("FAIL fill_full: got full=%b cnt=%0d want 1 16",
               s_full, s_count);
    end
    cyc(1, 0, 0, 32'hDEAD_BEEF);
    total++;
    if (s_ovf !== 1'b1 || s_count !== 5'd16 || f_ovf !== 1'b1) begin
      bad++;
      $display("FAIL fill_overflow: got ovf=%b cnt=%0d want 1 16",
               s_ovf, s_count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 1, 0, '0);
      total++;
      if (s_dout !== DW'(i)) begin
        bad++;
        $display("FAIL drain_data[%0d]: got %h want %h",
                 i, s_dout, DW'(i));
      end
      if (i < DEPTH) begin
        total++;
        if (f_dout !== DW'(i + 1)) begin
          bad++;
          $display("FAIL drain_fwft[%0d]: got %h want %h",
                   i, f_dout, DW'(i + 1));
        end
      end
    end
    total++;
    if (s_empty !== 1'b1 || s_unf !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: got empty=%b unf=%b want 1 0",
               s_empty, s_unf);
    end
    cyc(0, 1, 0, '0);
    total++;
    if (s_unf !== 1'b1 || f_unf !== 1'b1 || s_dout !== DW'(DEPTH)) begin
      bad++;
      $display("FAIL drain_underflow: got unf=%b dout=%h want 1 %h",
               s_unf, s_dout, DW'(DEPTH));
    end
  endtask

  task automatic test_full_rw();
    cyc(0, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, $urandom);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, $urandom);
      total++;
      if (s_count !== 5'd16 || s_ovf !== 1'b0 ||
          s_flags !== exp_flags()) begin
        bad++;
        $display("FAIL full_rw_flags[%0d]: got %b want %b",
                 i, s_flags, exp_flags());
      end
      total++;
      if (s_dout !== m_std || f_dout !== m_fw) begin
        bad++;
        $display("FAIL full_rw_data[%0d]: got %h / %h want %h / %h",
                 i, s_dout, f_dout, m_std, m_fw);
      end
    end
  endtask

  task automatic test_empty_rw();
    while (mq.size() != 0) cyc(0, 1, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(1, 1, 0, 32'h1234_5678);
    total++;
    if (s_count !== 5'd1 || s_unf !== 1'b1 || s_ovf !== 1'b0) begin
      bad++;
      $display("FAIL empty_rw: got cnt=%0d unf=%b ovf=%b want 1 1 0",
               s_count, s_unf, s_ovf);
    end
    total++;
    if (f_dout !== 32'h1234_5678) begin
      bad++;
      $display("FAIL empty_rw_fwft: got %h want 12345678", f_dout);
    end
    cyc(0, 0, 1, '0);
    total++;
    if (s_unf !== 1'b0 || s_ovf !== 1'b0 || f_unf !== 1'b0) begin
      bad++;
      $display("FAIL clr_err: got unf=%b ovf=%b want 0 0", s_unf, s_ovf);
    end
  endtask

  task automatic test_fwft();
    do_reset();
    cyc(1, 0, 0, 32'hA5A5_A5A5);
    total++;
    if (f_dout !== 32'hA5A5_A5A5 || f_count !== 5'd1 ||
        f_empty !== 1'b0) begin
      bad++;
      $display("FAIL fwft_first: got %h cnt=%0d empty=%b want a5a5a5a5 1 0",
               f_dout, f_count, f_empty);
    end
    cyc(0, 0, 0, '0);
    total++;
    if (f_dout !== 32'hA5A5_A5A5 || s_dout !== '0) begin
      bad++;
      $display("FAIL fwft_hold: got %h / std %h want a5a5a5a5 / 0",
               f_dout, s_dout);
    end
    cyc(0, 1, 0, '0);
    total++;
    if (f_empty !== 1'b1 || s_dout !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL fwft_pop: got empty=%b std=%h want 1 a5a5a5a5",
               f_empty, s_dout);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, $urandom);
    cyc(0, 1, 0, '0);
    cyc(1, 0, 0, $urandom);
    total++;
    if (s_count !== 5'd9) begin
      bad++;
      $display("FAIL mid_count: got %0d want 9", s_count);
    end
    wr_en   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    do_reset();
    wr_en = 1'b0;
    total++;
    if (s_flags !== 11'b00000_0_1_0_1_0_0 ||
        f_flags !== 11'b00000_0_1_0_1_0_0) begin
      bad++;
      $display("FAIL mid_reset_flags: got %b / %b want %b",
               s_flags, f_flags, 11'b00000_0_1_0_1_0_0);
    end
    total++;
    if (s_dout !== '0 || f_dout !== '0) begin
      bad++;
      $display("FAIL mid_reset_dout: got %h / %h want 0", s_dout, f_dout);
    end
    cyc(1, 0, 0, 32'h0BAD_F00D);
    total++;
    if (s_count !== 5'd1 || f_dout !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL mid_after: got cnt=%0d fwft=%h want 1 0badf00d",
               s_count, f_dout);
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int k = 0; k < 400; k++) begin
      if (k % 20 == 0) begin
        af_level = CW'($urandom_range(1, 16));
        ae_level = CW'($urandom_range(0, 16));
      end
      if (k % 50 == 0) begin
        af_level = '0;
        #1;
        total++;
        if (s_af !== 1'b1 || f_af !== 1'b1) begin
          bad++;
          $display("FAIL af_zero[%0d]: got %b / %b want 1", k, s_af, f_af);
        end
      end
      w = $urandom_range(0, 99) < ((k % 100 < 50) ? 75 : 30);
      r = $urandom_range(0, 99) < ((k % 100 < 50) ? 30 : 75);
      c = ($urandom_range(0, 15) == 0);
      cyc(w, r, c, $urandom);
      total++;
      if (s_flags !== exp_flags() || f_flags !== exp_flags()) begin
        bad++;
        $display("FAIL rand_flags[%0d]: got %b / %b want %b",
                 k, s_flags, f_flags, exp_flags());
      end
      total++;
      if (s_dout !== m_std) begin
        bad++;
        $display("FAIL rand_std[%0d]: got %h want %h", k, s_dout, m_std);
      end
      if (mq.size() != 0) begin
        total++;
        if (f_dout !== m_fw) begin
          bad++;
          $display("FAIL rand_fwft[%0d]: got %h want %h", k, f_dout, m_fw);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    data_in  = '0;
    af_level = 5'd14;
    ae_level = 5'd2;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_std    = '0;
    m_fw     = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
